// File: rtl/clock24_if.sv
// Signal bundle between the timebase/button side (master) and the
// 24-hour timekeeper core (slave).
interface clock24_if;
    logic       EN1HZ;
    logic       SIG2HZ;
    logic       MODE;
    logic       UP;
    logic [5:0] HOUR;
    logic [6:0] MIN;
    logic [6:0] SEC;
    logic [1:0] BLANK;
    logic       SETTING;
    logic       DAYCARRY;
    logic       CHIME;

    modport master (
        output EN1HZ, SIG2HZ, MODE, UP,
        input  HOUR, MIN, SEC, BLANK, SETTING, DAYCARRY, CHIME
    );

    modport slave (
        input  EN1HZ, SIG2HZ, MODE, UP,
        output HOUR, MIN, SEC, BLANK, SETTING, DAYCARRY, CHIME
    );
endinterface

// File: rtl/clock24_timekeeper.sv
// 24-hour BCD time-of-day core with a RUN / SET_HOUR / SET_MIN set-mode machine.
// Optional hourly chime enabled by defining CLOCK24_CHIME_EN; otherwise CHIME is 0.
//
// state    | meaning
// ---------+-------------------------------------------------
// RUN      | time advances on EN1HZ, UP ignored
// SET_HOUR | UP increments HOUR (wrap 23->00), SEC held at 00
// SET_MIN  | UP increments MIN (wrap 59->00), SEC held at 00
module clock24_timekeeper (
    input  logic       CLK,
    input  logic       RST,
    clock24_if.slave   bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] hour_q, hour_d;
    logic [6:0] min_q, min_d;
    logic [6:0] sec_q, sec_d;
    logic       daycarry_q, daycarry_d;
    logic       setting_q;

    // BCD 00..59 increment, wrapping 59 -> 00.
    function automatic logic [6:0] inc_bcd60(input logic [6:0] v);
        logic [6:0] r;
        if (v[3:0] == 4'd9) begin
            if (v[6:4] == 3'd5) r = 7'h00;
            else                r = {v[6:4] + 3'd1, 4'd0};
        end else begin
            r = {v[6:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // BCD 00..23 increment, wrapping 23 -> 00.
    function automatic logic [5:0] inc_bcd24(input logic [5:0] v);
        logic [5:0] r;
        if (v == 6'h23)            r = 6'h00;
        else if (v[3:0] == 4'd9)   r = {v[5:4] + 2'd1, 4'd0};
        else                       r = {v[5:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // State and time registers; SETTING tracks the state being entered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= RUN;
            hour_q     <= 6'h00;
            min_q      <= 7'h00;
            sec_q      <= 7'h00;
            daycarry_q <= 1'b0;
            setting_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            daycarry_q <= daycarry_d;
            setting_q  <= (state_d != RUN);
        end
    end

    // Next-state and next-time logic; MODE has priority over EN1HZ and UP.
    always_comb begin
        state_d    = state_q;
        hour_d     = hour_q;
        min_d      = min_q;
        sec_d      = sec_q;
        daycarry_d = 1'b0;
        unique case (state_q)
            RUN: begin
                if (bus.MODE) begin
                    state_d = SET_HOUR;
                    sec_d   = 7'h00;
                end else if (bus.EN1HZ) begin
                    sec_d = inc_bcd60(sec_q);
                    if (sec_q == 7'h59) begin
                        min_d = inc_bcd60(min_q);
                        if (min_q == 7'h59) begin
                            hour_d     = inc_bcd24(hour_q);
                            daycarry_d = (hour_q == 6'h23);
                        end
                    end
                end
            end
            SET_HOUR: begin
                if (bus.MODE)    state_d = SET_MIN;
                else if (bus.UP) hour_d  = inc_bcd24(hour_q);
            end
            SET_MIN: begin
                if (bus.MODE)    state_d = RUN;
                else if (bus.UP) min_d   = inc_bcd60(min_q);
            end
            default: state_d = RUN;
        endcase
    end

`ifdef CLOCK24_CHIME_EN
    logic chime_q;

    // Chime follows the time being loaded, so it rises with xx:00:00 and drops with leaving RUN.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) chime_q <= 1'b0;
        else     chime_q <= (state_d == RUN) && (min_d == 7'h00) && (sec_d < 7'h05);
    end

    assign bus.CHIME = chime_q;
`else
    assign bus.CHIME = 1'b0;
`endif

    assign bus.HOUR     = hour_q;
    assign bus.MIN      = min_q;
    assign bus.SEC      = sec_q;
    assign bus.DAYCARRY = daycarry_q;
    assign bus.SETTING  = setting_q;
    assign bus.BLANK    = {(state_q == SET_HOUR) && bus.SIG2HZ,
                           (state_q == SET_MIN)  && bus.SIG2HZ};

endmodule

// File: tb/tb_clock24_timekeeper.sv
// Self-checking bench for clock24_timekeeper: table of stimulus rows with
// hand-derived checkpoints, plus an integer reference model feeding a scoreboard.
`timescale 1ns/1ps
module tb_clock24_timekeeper;

`ifdef CLOCK24_CHIME_EN
    localparam bit CHIME_ON = 1'b1;
`else
    localparam bit CHIME_ON = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #10 CLK = ~CLK;

    clock24_if bus();

    clock24_timekeeper dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct packed {
        logic [5:0] hour;
        logic [6:0] min;
        logic [6:0] sec;
        logic [1:0] blank;
        logic       setting;
        logic       daycarry;
        logic       chime;
    } exp_t;

    typedef struct {
        logic rst;
        logic en;
        logic s2;
        logic md;
        logic up;
        int   rep;
        int   eh;
        int   em;
        int   es;
        logic eset;
        int   eblank;
        logic edc;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int   mh = 0, mm = 0, ms = 0, mst = 0;

    function automatic vec_t mkv(input logic rst, input logic en, input logic s2,
                                 input logic md, input logic up, input int rep,
                                 input int eh, input int em, input int es,
                                 input logic eset, input int eblank, input logic edc);
        vec_t v;
        v.rst = rst; v.en = en; v.s2 = s2; v.md = md; v.up = up; v.rep = rep;
        v.eh = eh; v.em = em; v.es = es; v.eset = eset; v.eblank = eblank; v.edc = edc;
        return v;
    endfunction

    function automatic int bcd(input int n);
        return ((n / 10) << 4) | (n % 10);
    endfunction

    function automatic exp_t mk_exp(input logic s2, input logic dc, input logic ch);
        exp_t e;
        e.hour     = 6'(bcd(mh));
        e.min      = 7'(bcd(mm));
        e.sec      = 7'(bcd(ms));
        e.blank    = {(mst == 1) && s2, (mst == 2) && s2};
        e.setting  = (mst != 0);
        e.daycarry = dc;
        e.chime    = ch;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("hour",     int'(bus.HOUR),     int'(e.hour));
            chk("min",      int'(bus.MIN),      int'(e.min));
            chk("sec",      int'(bus.SEC),      int'(e.sec));
            chk("blank",    int'(bus.BLANK),    int'(e.blank));
            chk("setting",  int'(bus.SETTING),  int'(e.setting));
            chk("daycarry", int'(bus.DAYCARRY), int'(e.daycarry));
            chk("chime",    int'(bus.CHIME),    int'(e.chime));
        end
    endtask

    task automatic model_step(input logic e, input logic s2, input logic md, input logic u);
        logic dc;
        logic ch;
        dc = 1'b0;
        case (mst)
            0: begin
                if (md) begin
                    mst = 1;
                    ms  = 0;
                end else if (e) begin
                    ms++;
                    if (ms == 60) begin
                        ms = 0;
                        mm++;
                        if (mm == 60) begin
                            mm = 0;
                            mh++;
                            if (mh == 24) begin
                                mh = 0;
                                dc = 1'b1;
                            end
                        end
                    end
                end
            end
            1: if (md) mst = 2; else if (u) mh = (mh + 1) % 24;
            default: if (md) mst = 0; else if (u) mm = (mm + 1) % 60;
        endcase
        ch = CHIME_ON && (mst == 0) && (mm == 0) && (ms < 5);
        sb.push_back(mk_exp(s2, dc, ch));
    endtask

    task automatic cycle(input logic e, input logic s2, input logic md, input logic u);
        bus.EN1HZ  = e;
        bus.SIG2HZ = s2;
        bus.MODE   = md;
        bus.UP     = u;
        model_step(e, s2, md, u);
        @(posedge CLK);
        #1;
        compare_out();
    endtask

    task automatic model_reset();
        mh = 0; mm = 0; ms = 0; mst = 0;
        sb.delete();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #2;
        model_reset();
        sb.push_back(mk_exp(bus.SIG2HZ, 1'b0, 1'b0));
        compare_out();
        #2;
        RST = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.EN1HZ  = 1'b0;
        bus.SIG2HZ = 1'b0;
        bus.MODE   = 1'b0;
        bus.UP     = 1'b0;

        //                rst en s2 md up rep  h   m   s  set blank dc
        vecs.push_back(mkv(1, 0, 0, 0, 0,  1,  0,  0,  0, 0, 0, 0));
        vecs.push_back(mkv(0, 1, 0, 0, 0, 61,  0,  1,  1, 0, 0, 0));
        vecs.push_back(mkv(1, 0, 0, 0, 0,  1,  0,  0,  0, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 1, 0,  1,  0,  0,  0, 1, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 1, 25,  1,  0,  0, 1, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 1, 0,  1,  1,  0,  0, 1, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 1, 61,  1,  1,  0, 1, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 1, 0,  1,  1,  1,  0, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 1, 0,  1,  1,  1,  0, 1, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 1, 22, 23,  1,  0, 1, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 1, 0,  1, 23,  1,  0, 1, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 1, 58, 23, 59,  0, 1, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 1, 0,  1, 23, 59,  0, 0, 0, 0));
        vecs.push_back(mkv(0, 1, 0, 0, 0, 59, 23, 59, 59, 0, 0, 0));
        vecs.push_back(mkv(0, 1, 0, 0, 0,  1,  0,  0,  0, 0, 0, 1));
        vecs.push_back(mkv(0, 0, 0, 0, 0,  1,  0,  0,  0, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 1, 1, 0,  1,  0,  0,  0, 1, 2, 0));
        vecs.push_back(mkv(0, 1, 1, 0, 0,  3,  0,  0,  0, 1, 2, 0));
        vecs.push_back(mkv(0, 1, 0, 0, 0,  2,  0,  0,  0, 1, 0, 0));
        vecs.push_back(mkv(0, 0, 1, 1, 0,  1,  0,  0,  0, 1, 1, 0));
        vecs.push_back(mkv(0, 1, 1, 1, 0,  1,  0,  0,  0, 0, 0, 0));
        vecs.push_back(mkv(0, 1, 0, 0, 0, 30,  0,  0, 30, 0, 0, 0));
        vecs.push_back(mkv(0, 1, 0, 1, 0,  1,  0,  0,  0, 1, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 1, 1,  1,  0,  0,  0, 1, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 1,  5,  0,  5,  0, 1, 0, 0));

        #5;
        foreach (vecs[k]) begin
            if (vecs[k].rst) begin
                do_reset();
            end else begin
                for (int r = 0; r < vecs[k].rep; r++)
                    cycle(vecs[k].en, vecs[k].s2, vecs[k].md, vecs[k].up);
            end
            chk($sformatf("row%0d_hour", k),     int'(bus.HOUR),     bcd(vecs[k].eh));
            chk($sformatf("row%0d_min", k),      int'(bus.MIN),      bcd(vecs[k].em));
            chk($sformatf("row%0d_sec", k),      int'(bus.SEC),      bcd(vecs[k].es));
            chk($sformatf("row%0d_setting", k),  int'(bus.SETTING),  int'(vecs[k].eset));
            chk($sformatf("row%0d_blank", k),    int'(bus.BLANK),    vecs[k].eblank);
            chk($sformatf("row%0d_daycarry", k), int'(bus.DAYCARRY), int'(vecs[k].edc));
        end

        // Asynchronous reset mid-cycle while in SET_MIN at 00:05:00.
        bus.MODE = 1'b0; bus.UP = 1'b0; bus.EN1HZ = 1'b0; bus.SIG2HZ = 1'b1;
        #4;
        RST = 1'b1;
        #1;
        chk("async_rst_hour",    int'(bus.HOUR),    0);
        chk("async_rst_min",     int'(bus.MIN),     0);
        chk("async_rst_setting", int'(bus.SETTING), 0);
        chk("async_rst_blank",   int'(bus.BLANK),   0);
        chk("async_rst_chime",   int'(bus.CHIME),   0);
        #2;
        RST = 1'b0;
        model_reset();
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);

        // Hourly chime: set 00:59, count to 00:59:58, then across the hour.
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 59; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 58; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre_hour_sec", int'(bus.SEC), bcd(58));
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            if (i == 1) begin
                chk("top_hour",  int'(bus.HOUR),  bcd(1));
                chk("top_min",   int'(bus.MIN),   0);
                chk("top_chime", int'(bus.CHIME), int'(CHIME_ON));
            end
            if (i == 6) begin
                chk("chime_end_sec", int'(bus.SEC),   bcd(5));
                chk("chime_end",     int'(bus.CHIME), 0);
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
